// File: rtl/struct_hazard_mem_arbiter_if.sv
// Request/grant bundle between the IF/MEM pipeline stages and the unified-memory arbiter.
// master = pipeline side (drives requests), slave = arbiter side (drives grants and port control).
interface struct_hazard_mem_arbiter_if;
  logic IF_MemReq;
  logic MEM_MemReq;
  logic MEM_IsWrite;
  logic mem_start;
  logic mem_sel;
  logic mem_we;
  logic IF_Grant;
  logic MEM_Grant;
  logic IF_Done;
  logic MEM_Done;
  logic STALL_IF;
  logic STALL_MEM;
  logic busy;

  modport master (
    output IF_MemReq, MEM_MemReq, MEM_IsWrite,
    input  mem_start, mem_sel, mem_we, IF_Grant, MEM_Grant,
    input  IF_Done, MEM_Done, STALL_IF, STALL_MEM, busy
  );

  modport slave (
    input  IF_MemReq, MEM_MemReq, MEM_IsWrite,
    output mem_start, mem_sel, mem_we, IF_Grant, MEM_Grant,
    output IF_Done, MEM_Done, STALL_IF, STALL_MEM, busy
  );
endinterface

// File: rtl/struct_hazard_mem_arbiter.sv
// Single-port unified memory arbiter: serialises IF and MEM accesses with MEM priority,
// an IF anti-starvation guard and zero-bubble back-to-back grants.
module struct_hazard_mem_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic clk,
  input  logic rst,
  struct_hazard_mem_arbiter_if.slave bus
);
  localparam int LAT_W = $clog2(MEM_LAT + 1);
  localparam int ST_W  = $clog2(STARVE_MAX + 1);
  localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(MEM_LAT - 1);
  localparam logic [ST_W-1:0]  ST_MAX    = ST_W'(STARVE_MAX);
  localparam logic             ONE_CYCLE = (MEM_LAT == 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM} state_t;

  state_t           state;
  logic [LAT_W-1:0] lat_cnt;
  logic [ST_W-1:0]  starve_cnt;
  logic             start_q, sel_q, we_q, if_gnt_q, mem_gnt_q, if_done_q, mem_done_q, busy_q;

  logic             arb_en, eff_if, eff_mem, pick_mem, pick_if, last_nxt;
  logic [LAT_W-1:0] lat_nxt;

  function automatic logic [ST_W-1:0] sat_inc(input logic [ST_W-1:0] v);
    return (v == ST_MAX) ? v : v + 1'b1;
  endfunction

  // The requester finishing this cycle is masked so the other side gets the next slot.
  assign arb_en   = (state == IDLE) | if_done_q | mem_done_q;
  assign eff_if   = bus.IF_MemReq  & ~if_done_q;
  assign eff_mem  = bus.MEM_MemReq & ~mem_done_q;
  assign pick_mem = eff_mem & (~eff_if | (starve_cnt < ST_MAX));
  assign pick_if  = eff_if & ~pick_mem;
  assign lat_nxt  = lat_cnt + 1'b1;
  assign last_nxt = (lat_nxt == LAT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      start_q    <= 1'b0;
      sel_q      <= 1'b0;
      we_q       <= 1'b0;
      if_gnt_q   <= 1'b0;
      mem_gnt_q  <= 1'b0;
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      busy_q     <= 1'b0;
    end else if (arb_en) begin
      lat_cnt    <= '0;
      start_q    <= pick_mem | pick_if;
      busy_q     <= pick_mem | pick_if;
      if_gnt_q   <= pick_if;
      mem_gnt_q  <= pick_mem;
      sel_q      <= pick_mem;
      we_q       <= pick_mem & bus.MEM_IsWrite;
      if_done_q  <= pick_if  & ONE_CYCLE;
      mem_done_q <= pick_mem & ONE_CYCLE;
      if (pick_mem)     state <= BUSY_MEM;
      else if (pick_if) state <= BUSY_IF;
      else              state <= IDLE;
      if (pick_if)                starve_cnt <= '0;
      else if (pick_mem & eff_if) starve_cnt <= sat_inc(starve_cnt);
    end else begin
      start_q    <= 1'b0;
      lat_cnt    <= lat_nxt;
      if_done_q  <= if_gnt_q  & last_nxt;
      mem_done_q <= mem_gnt_q & last_nxt;
    end
  end

  assign bus.mem_start = start_q;
  assign bus.mem_sel   = sel_q;
  assign bus.mem_we    = we_q;
  assign bus.IF_Grant  = if_gnt_q;
  assign bus.MEM_Grant = mem_gnt_q;
  assign bus.IF_Done   = if_done_q;
  assign bus.MEM_Done  = mem_done_q;
  assign bus.busy      = busy_q;
  assign bus.STALL_IF  = bus.IF_MemReq  & ~if_done_q;
  assign bus.STALL_MEM = bus.MEM_MemReq & ~mem_done_q;
endmodule

// File: tb/tb_struct_hazard_mem_arbiter.sv
// Bench for struct_hazard_mem_arbiter: two instances (MEM_LAT=2/STARVE_MAX=3 and MEM_LAT=1/STARVE_MAX=1)
// driven in lockstep and compared every cycle with a countdown-based reference model.
module tb_struct_hazard_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   total  = 0;
  int   passed = 0;

  struct_hazard_mem_arbiter_if bus0();
  struct_hazard_mem_arbiter_if bus1();

  struct_hazard_mem_arbiter #(.MEM_LAT(2), .STARVE_MAX(3)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  struct_hazard_mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  // owner: 0 none, 1 IF, 2 MEM; left: cycles remaining in the access including the current one
  typedef struct {
    int owner;
    int left;
    int starve;
    bit start;
    bit we;
  } mdl_t;

  mdl_t md [2];
  int   lat [2] = '{2, 1};
  int   smx [2] = '{3, 1};
  bit   cur_i, cur_m, cur_w;

  function automatic mdl_t mreset();
    mdl_t r;
    r.owner = 0; r.left = 0; r.starve = 0; r.start = 0; r.we = 0;
    return r;
  endfunction

  function automatic mdl_t mstep(mdl_t s, bit i, bit m, bit w, int l, int sm);
    mdl_t n = s;
    bit fin = (s.owner != 0) && (s.left == 1);
    bit eif, emem;
    n.start = 0;
    if (s.owner != 0 && !fin) begin
      n.left = s.left - 1;
      return n;
    end
    eif  = i && !(fin && s.owner == 1);
    emem = m && !(fin && s.owner == 2);
    if (emem && (!eif || s.starve < sm)) begin
      n.owner = 2; n.left = l; n.start = 1; n.we = w;
      if (eif) n.starve = s.starve + 1;
    end else if (eif) begin
      n.owner = 1; n.left = l; n.start = 1; n.we = 0; n.starve = 0;
    end else begin
      n.owner = 0; n.left = 0; n.we = 0;
    end
    return n;
  endfunction

  function automatic logic [9:0] exp_vec(mdl_t s, bit i, bit m);
    logic fin, ifd, memd;
    fin  = (s.owner != 0) && (s.left == 1);
    ifd  = fin && (s.owner == 1);
    memd = fin && (s.owner == 2);
    return {s.start, logic'(s.owner == 2), logic'(s.owner == 2 && s.we), logic'(s.owner == 1),
            logic'(s.owner == 2), ifd, memd, logic'(i & ~ifd), logic'(m & ~memd), logic'(s.owner != 0)};
  endfunction

  function automatic logic [9:0] obs_vec(int k);
    if (k == 0)
      return {bus0.mem_start, bus0.mem_sel, bus0.mem_we, bus0.IF_Grant, bus0.MEM_Grant,
              bus0.IF_Done, bus0.MEM_Done, bus0.STALL_IF, bus0.STALL_MEM, bus0.busy};
    return {bus1.mem_start, bus1.mem_sel, bus1.mem_we, bus1.IF_Grant, bus1.MEM_Grant,
            bus1.IF_Done, bus1.MEM_Done, bus1.STALL_IF, bus1.STALL_MEM, bus1.busy};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic cmp_all(input string tag);
    logic [9:0] o;
    for (int k = 0; k < 2; k++) begin
      o = obs_vec(k);
      chk($sformatf("%s_dut%0d_outs", tag, k), {6'd0, o}, {6'd0, exp_vec(md[k], cur_i, cur_m)});
      chk($sformatf("%s_dut%0d_one_grant", tag, k), {15'd0, o[6] & o[5]}, 16'd0);
      chk($sformatf("%s_dut%0d_one_done", tag, k), {15'd0, o[4] & o[3]}, 16'd0);
    end
  endtask

  task automatic set_in(input bit i, input bit m, input bit w);
    cur_i = i; cur_m = m; cur_w = w;
    bus0.IF_MemReq = i; bus0.MEM_MemReq = m; bus0.MEM_IsWrite = w;
    bus1.IF_MemReq = i; bus1.MEM_MemReq = m; bus1.MEM_IsWrite = w;
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
  task automatic step(input bit i, input bit m, input bit w);
    set_in(i, m, w);
    #4;
    cmp_all("cyc");
    @(posedge clk);
    for (int k = 0; k < 2; k++) md[k] = mstep(md[k], i, m, w, lat[k], smx[k]);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0);
    md[0] = mreset(); md[1] = mreset();
    #1;
    cmp_all("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single IF request
    step(1, 0, 0);
    chk("t1_start", bus0.mem_start, 1);
    chk("t1_ifgrant", bus0.IF_Grant, 1);
    step(1, 0, 0);
    chk("t1_ifdone", bus0.IF_Done, 1);
    step(1, 0, 0);
    chk("t1_idle", bus0.busy, 0);
    repeat (3) step(0, 0, 0);

    // Simultaneous requests: MEM first, IF back-to-back
    step(1, 1, 0);
    chk("t2_memgrant", bus0.MEM_Grant, 1);
    step(1, 1, 0);
    chk("t2_memdone", bus0.MEM_Done, 1);
    step(1, 1, 0);
    chk("t2_b2b_start", bus0.mem_start, 1);
    chk("t2_b2b_ifgrant", bus0.IF_Grant, 1);
    step(1, 0, 0);
    chk("t2_ifdone", bus0.IF_Done, 1);
    step(1, 0, 0);
    chk("t2_idle", bus0.busy, 0);
    repeat (2) step(0, 0, 0);

    // Starvation guard: three MEM wins over a pending IF, then IF is forced
    repeat (3) begin
      step(1, 1, 0);
      chk("t3_memwin", bus0.MEM_Grant, 1);
      step(0, 1, 0);
      step(0, 1, 0);
      step(0, 0, 0);
    end
    step(1, 1, 0);
    chk("t3_forced_if", bus0.IF_Grant, 1);
    chk("t3_forced_nomem", bus0.MEM_Grant, 0);
    step(1, 1, 0);
    step(1, 1, 0);
    chk("t3_mem_after_if", bus0.MEM_Grant, 1);
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    step(1, 1, 0);
    chk("t3_starve_cleared", bus0.MEM_Grant, 1);
    step(0, 1, 0);
    step(0, 1, 0);
    repeat (2) step(0, 0, 0);

    // Store latched at grant, request dropped mid-access
    step(0, 1, 1);
    chk("t4_we_c1", bus0.mem_we, 1);
    chk("t4_sel_c1", bus0.mem_sel, 1);
    step(0, 0, 0);
    chk("t4_we_c2", bus0.mem_we, 1);
    chk("t4_memdone", bus0.MEM_Done, 1);
    step(0, 0, 0);
    chk("t4_we_idle", bus0.mem_we, 0);
    step(0, 0, 0);

    // Asynchronous reset in the middle of a MEM access
    step(0, 1, 0);
    chk("t5_memgrant", bus0.MEM_Grant, 1);
    rst = 1'b1;
    #1;
    md[0] = mreset(); md[1] = mreset();
    cmp_all("t5_async");
    @(posedge clk);
    #1;
    chk("t5_no_memdone", bus0.MEM_Done, 0);
    cmp_all("t5_held");
    rst = 1'b0;
    step(0, 1, 0);
    chk("t5_reserve_start", bus0.mem_start, 1);
    chk("t5_reserve_grant", bus0.MEM_Grant, 1);
    step(0, 1, 0);
    step(0, 1, 0);
    repeat (2) step(0, 0, 0);

    // Randomised traffic against the reference model
    for (int n = 0; n < 400; n++)
      step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 60, $urandom_range(0, 1) == 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
